// File: rtl/fbosc_ring.sv
// Feedback shift-register oscillator: one-hot ring or Johnson sequence with
// prescaled stepping, direction control, parallel load and illegal-state recovery.
module fbosc_ring #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             wrap,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

    logic [DIV_W-1:0] pcnt;
    logic [CNT_W-1:0] ones_c;
    logic [CNT_W-1:0] edges_c;
    logic             legal_c;
    logic             step_c;
    logic [WIDTH-1:0] shifted_c;

    // Legality: ring needs exactly one hot bit, Johnson at most one 0/1 boundary.
    always_comb begin
        ones_c  = '0;
        edges_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_c = ones_c + CNT_W'(q[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            edges_c = edges_c + CNT_W'(q[i] ^ q[i+1]);
        end
        legal_c = mode ? (edges_c <= CNT_W'(1)) : (ones_c == CNT_W'(1));
    end

    // Next shifted value for the current mode and direction.
    always_comb begin
        shifted_c = q;
        case ({mode, dir})
            2'b00:   shifted_c = {q[WIDTH-2:0], q[WIDTH-1]};
            2'b01:   shifted_c = {q[0], q[WIDTH-1:1]};
            2'b10:   shifted_c = {q[WIDTH-2:0], ~q[WIDTH-1]};
            default: shifted_c = {~q[0], q[WIDTH-1:1]};
        endcase
    end

    assign step_c = en && !load && (pcnt == div);

    // State, prescaler and single-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= SEED;
            pcnt <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
            if (load) begin
                q    <= load_val;
                pcnt <= '0;
            end else if (step_c) begin
                pcnt <= '0;
                if (legal_c) begin
                    q    <= shifted_c;
                    tick <= 1'b1;
                    wrap <= (shifted_c == SEED);
                end else begin
                    q   <= SEED;
                    err <= 1'b1;
                end
            end else if (en) begin
                pcnt <= pcnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fbosc_ring.sv
// Self-checking bench for fbosc_ring: directed plan steps plus a randomized run
// compared every cycle against an arithmetic reference model.
module tb_fbosc_ring;

    localparam int unsigned W     = 4;
    localparam int unsigned DW    = 8;
    localparam int          MASK  = (1 << W) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic          mode;
    logic          dir;
    logic [DW-1:0] div;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  q;
    logic          tick;
    logic          wrap;
    logic          err;

    int checks;
    int errors;

    int m_q;
    int m_pcnt;
    int m_tick;
    int m_wrap;
    int m_err;

    fbosc_ring #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .div      (div),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tick     (tick),
        .wrap     (wrap),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input int v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += (v >> i) & 1;
        return n;
    endfunction

    task automatic model_reset();
        m_q = 1; m_pcnt = 0; m_tick = 0; m_wrap = 0; m_err = 0;
    endtask

    // Reference: one clock edge worth of behaviour, from the sampled inputs.
    task automatic model_edge();
        int  nxt;
        bit  ok;
        m_tick = 0; m_wrap = 0; m_err = 0;
        if (load) begin
            m_q = int'(load_val);
            m_pcnt = 0;
        end else if (en) begin
            if (m_pcnt == int'(div)) begin
                m_pcnt = 0;
                if (mode) ok = popc((m_q ^ (m_q >> 1)) & (MASK >> 1)) <= 1;
                else      ok = popc(m_q) == 1;
                if (ok) begin
                    if (!mode && !dir)     nxt = ((m_q << 1) | (m_q >> (W - 1))) & MASK;
                    else if (!mode && dir) nxt = (m_q >> 1) | ((m_q & 1) << (W - 1));
                    else if (mode && !dir) nxt = ((m_q << 1) & MASK) | (((m_q >> (W - 1)) & 1) ^ 1);
                    else                   nxt = (m_q >> 1) | (((~m_q) & 1) << (W - 1));
                    m_q = nxt;
                    m_tick = 1;
                    m_wrap = (nxt == 1) ? 1 : 0;
                end else begin
                    m_q = 1;
                    m_err = 1;
                end
            end else begin
                m_pcnt = (m_pcnt + 1) % (1 << DW);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_edge();
        chk("q_model",    32'(q),    32'(m_q));
        chk("tick_model", 32'(tick), 32'(m_tick));
        chk("wrap_model", 32'(wrap), 32'(m_wrap));
        chk("err_model",  32'(err),  32'(m_err));
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_val = v;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ring_seq [4];
        logic [W-1:0] john_seq [8];
        ring_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        john_seq = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        checks = 0; errors = 0;
        rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; div = '0; load = 1'b0; load_val = '0;
        model_reset();
        #12;
        chk("reset_q", 32'(q), 32'h1);
        chk("reset_pulses", 32'({tick, wrap, err}), 32'h0);
        rst = 1'b1;
        en = 1'b1;

        // Ring stepping, div=0
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ring_q", 32'(q), 32'(ring_seq[i]));
            chk("ring_tick", 32'(tick), 32'h1);
            chk("ring_wrap", 32'(wrap), (i == 3) ? 32'h1 : 32'h0);
        end

        // Johnson forward, then reverse from 0111
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("john_q", 32'(q), 32'(john_seq[i]));
            chk("john_wrap", 32'(wrap), (i == 7) ? 32'h1 : 32'h0);
        end
        cyc(); cyc();
        chk("john_at_0111", 32'(q), 32'h7);
        dir = 1'b1;
        cyc();
        chk("john_rev", 32'(q), 32'h3);

        // Prescaler div=2 with an enable gap
        mode = 1'b0; dir = 1'b0; div = 8'd2;
        do_load(4'b0001);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("presc_tick", 32'(tick), (i % 3 == 2) ? 32'h1 : 32'h0);
        end
        chk("presc_q", 32'(q), 32'h4);
        cyc();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_q", 32'(q), 32'h4);
            chk("hold_tick", 32'(tick), 32'h0);
        end
        en = 1'b1;
        cyc();
        chk("resume_notick", 32'(tick), 32'h0);
        cyc();
        chk("resume_tick", 32'(tick), 32'h1);
        chk("resume_q", 32'(q), 32'h8);

        // Illegal-state correction
        div = '0;
        mode = 1'b0; do_load(4'b0110); cyc();
        chk("ill_ring_q", 32'(q), 32'h1);
        chk("ill_ring_err", 32'({err, tick}), 32'h2);
        mode = 1'b1; do_load(4'b0110); cyc();
        chk("ill_john_q", 32'(q), 32'h1);
        chk("ill_john_err", 32'({err, tick}), 32'h2);
        mode = 1'b0; do_load(4'b0011); cyc();
        chk("ill_0011_ring", 32'({q, err}), 32'h3);
        mode = 1'b1; do_load(4'b0011); cyc();
        chk("ok_0011_john", 32'({q, err, tick}), 32'h1D);

        // Load wins over a due step
        mode = 1'b0; div = 8'd2;
        do_load(4'b0001);
        cyc(); cyc();
        load = 1'b1; load_val = 4'b0100;
        cyc();
        load = 1'b0;
        chk("ldpri_q", 32'(q), 32'h4);
        chk("ldpri_tick", 32'(tick), 32'h0);
        cyc(); cyc();
        chk("ldpri_wait", 32'(tick), 32'h0);
        cyc();
        chk("ldpri_step", 32'({q, tick}), 32'h11);

        // Asynchronous reset between edges with q=0100, pcnt=1
        div = 8'd3;
        do_load(4'b0100);
        cyc();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("areset_q", 32'(q), 32'h1);
        chk("areset_pulses", 32'({tick, wrap, err}), 32'h0);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_reset_tick", 32'(tick), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("post_reset_q", 32'(q), 32'h2);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            if ($urandom_range(0, 19) == 0) div = DW'($urandom_range(0, 3));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
